// File: rtl/ex_mem_if.sv
// EX -> MEM pipeline-register bus.
// master: EX-stage side (drives in*, observes out*).
// slave:  the pipeline register itself.
interface ex_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 8
);
  // Control from the hazard unit
  logic              inStall;
  logic              inFlush;

  // EX-stage instruction
  logic              inValid;
  logic [DATA_W-1:0] inAluResult;
  logic [DATA_W-1:0] inWriteData;
  logic [REG_W-1:0]  inWriteReg;
  logic              inRegWrite;
  logic              inMemtoReg;
  logic              inMemWrite;
  logic              inMemRead;
  logic [1:0]        inSize;

  // MEM-stage view
  logic [DATA_W-1:0] outMemAddress;
  logic [DATA_W-1:0] outMemWriteData;
  logic [REG_W-1:0]  outWriteReg;
  logic              outRegWrite;
  logic              outMemtoReg;
  logic              MemWrite;
  logic              MemRead;
  logic [3:0]        outByteEn;
  logic              outValid;
  logic              outMisalign;
  logic [CNT_W-1:0]  outMisalignCnt;

  modport master (
    output inStall, inFlush, inValid, inAluResult, inWriteData, inWriteReg,
           inRegWrite, inMemtoReg, inMemWrite, inMemRead, inSize,
    input  outMemAddress, outMemWriteData, outWriteReg, outRegWrite, outMemtoReg,
           MemWrite, MemRead, outByteEn, outValid, outMisalign, outMisalignCnt
  );

  modport slave (
    input  inStall, inFlush, inValid, inAluResult, inWriteData, inWriteReg,
           inRegWrite, inMemtoReg, inMemWrite, inMemRead, inSize,
    output outMemAddress, outMemWriteData, outWriteReg, outRegWrite, outMemtoReg,
           MemWrite, MemRead, outByteEn, outValid, outMisalign, outMisalignCnt
  );
endinterface

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with stall, flush, misaligned-access suppression
// and a saturating misalign event counter.
// Optional macro BYTE_LANE_EN: honour inSize for sub-word accesses (lane
// enables and store-data replication). Undefined: every access is a word.
module ex_mem_register #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 8
) (
  input logic     clk,
  input logic     rst,
  ex_mem_if.slave bus
);

  logic [DATA_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic              reg_write_q, reg_write_d;
  logic              memto_reg_q, memto_reg_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  logic [3:0]        byte_en_q, byte_en_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              is_mem_access;
  logic              misaligned;
  logic              misalign_hit;
  logic [3:0]        store_be;
  logic [DATA_W-1:0] store_data;

  assign is_mem_access = bus.inValid & (bus.inMemWrite | bus.inMemRead);
  assign misalign_hit  = is_mem_access & misaligned;

`ifdef BYTE_LANE_EN
  // Size-aware alignment check and lane steering for stores
  always_comb begin
    misaligned = 1'b0;
    store_be   = 4'b1111;
    store_data = bus.inWriteData;
    unique case (bus.inSize)
      2'b01: begin
        misaligned = bus.inAluResult[0];
        store_be   = 4'b0011 << bus.inAluResult[1:0];
        store_data = {(DATA_W / 16){bus.inWriteData[15:0]}};
      end
      2'b10: begin
        misaligned = 1'b0;
        store_be   = 4'b0001 << bus.inAluResult[1:0];
        store_data = {(DATA_W / 8){bus.inWriteData[7:0]}};
      end
      default: begin
        // 00 and 11 are both word accesses
        misaligned = (bus.inAluResult[1:0] != 2'b00);
        store_be   = 4'b1111;
        store_data = bus.inWriteData;
      end
    endcase
  end
`else
  logic unused_size;
  assign unused_size = ^bus.inSize;

  // Every access is a word: full-lane stores, data unchanged
  always_comb begin
    misaligned = (bus.inAluResult[1:0] != 2'b00);
    store_be   = 4'b1111;
    store_data = bus.inWriteData;
  end
`endif

  // Next-state: flush beats stall beats normal load
  always_comb begin
    mem_address_d = mem_address_q;
    write_data_d  = write_data_q;
    write_reg_d   = write_reg_q;
    reg_write_d   = reg_write_q;
    memto_reg_d   = memto_reg_q;
    mem_write_d   = mem_write_q;
    mem_read_d    = mem_read_q;
    byte_en_d     = byte_en_q;
    valid_d       = valid_q;
    misalign_d    = misalign_q;
    cnt_d         = cnt_q;

    if (bus.inFlush) begin
      // Bubble; the counter deliberately keeps its value
      mem_address_d = '0;
      write_data_d  = '0;
      write_reg_d   = '0;
      reg_write_d   = 1'b0;
      memto_reg_d   = 1'b0;
      mem_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      byte_en_d     = 4'b0000;
      valid_d       = 1'b0;
      misalign_d    = 1'b0;
    end else if (!bus.inStall) begin
      valid_d       = bus.inValid;
      mem_address_d = bus.inAluResult;
      write_reg_d   = bus.inWriteReg;
      memto_reg_d   = bus.inValid & bus.inMemtoReg;
      // A misaligned access stays valid but must not touch memory or the RF
      reg_write_d   = bus.inValid & bus.inRegWrite & ~misalign_hit;
      mem_write_d   = bus.inValid & bus.inMemWrite & ~misalign_hit;
      mem_read_d    = bus.inValid & bus.inMemRead & ~misalign_hit;
      misalign_d    = misalign_hit;
      byte_en_d     = mem_write_d ? store_be : 4'b0000;
      write_data_d  = mem_write_d ? store_data : bus.inWriteData;
      if (misalign_hit && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_address_q <= '0;
      write_data_q  <= '0;
      write_reg_q   <= '0;
      reg_write_q   <= 1'b0;
      memto_reg_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      byte_en_q     <= 4'b0000;
      valid_q       <= 1'b0;
      misalign_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      mem_address_q <= mem_address_d;
      write_data_q  <= write_data_d;
      write_reg_q   <= write_reg_d;
      reg_write_q   <= reg_write_d;
      memto_reg_q   <= memto_reg_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      byte_en_q     <= byte_en_d;
      valid_q       <= valid_d;
      misalign_q    <= misalign_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.outMemAddress   = mem_address_q;
  assign bus.outMemWriteData = write_data_q;
  assign bus.outWriteReg     = write_reg_q;
  assign bus.outRegWrite     = reg_write_q;
  assign bus.outMemtoReg     = memto_reg_q;
  assign bus.MemWrite        = mem_write_q;
  assign bus.MemRead         = mem_read_q;
  assign bus.outByteEn       = byte_en_q;
  assign bus.outValid        = valid_q;
  assign bus.outMisalign     = misalign_q;
  assign bus.outMisalignCnt  = cnt_q;

endmodule

// File: tb/tb_ex_mem_register.sv
// Directed bench for ex_mem_register: vector table plus hand sequences for
// reset, stall/flush and counter saturation.
module tb_ex_mem_register;

`ifdef BYTE_LANE_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic clk;
  logic rst;

  ex_mem_if #(.DATA_W(32), .REG_W(5), .CNT_W(8)) bus ();

  ex_mem_register #(.DATA_W(32), .REG_W(5), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        memto_reg;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wreg;
  } in_t;

  typedef struct packed {
    logic        mem_write;
    logic        mem_read;
    logic        reg_write;
    logic        memto_reg;
    logic        valid;
    logic        misalign;
    logic [3:0]  byte_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic [7:0]  cnt;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic in_t mk_in(input logic v, rw, m2r, mw, mr, input logic [1:0] sz,
                                input logic [31:0] a, d, input logic [4:0] r);
    in_t t;
    t.valid = v; t.reg_write = rw; t.memto_reg = m2r; t.mem_write = mw; t.mem_read = mr;
    t.size = sz; t.addr = a; t.wdata = d; t.wreg = r;
    return t;
  endfunction

  function automatic out_t mk_out(input logic mw, mr, rw, m2r, v, mis, input logic [3:0] be,
                                  input logic [31:0] a, d, input logic [4:0] r,
                                  input logic [7:0] c);
    out_t t;
    t.mem_write = mw; t.mem_read = mr; t.reg_write = rw; t.memto_reg = m2r; t.valid = v;
    t.misalign = mis; t.byte_en = be; t.addr = a; t.wdata = d; t.wreg = r; t.cnt = c;
    return t;
  endfunction

  function automatic out_t sample();
    out_t t;
    t.mem_write = bus.MemWrite;
    t.mem_read  = bus.MemRead;
    t.reg_write = bus.outRegWrite;
    t.memto_reg = bus.outMemtoReg;
    t.valid     = bus.outValid;
    t.misalign  = bus.outMisalign;
    t.byte_en   = bus.outByteEn;
    t.addr      = bus.outMemAddress;
    t.wdata     = bus.outMemWriteData;
    t.wreg      = bus.outWriteReg;
    t.cnt       = bus.outMisalignCnt;
    return t;
  endfunction

  task automatic apply(input in_t v);
    bus.inValid     = v.valid;
    bus.inRegWrite  = v.reg_write;
    bus.inMemtoReg  = v.memto_reg;
    bus.inMemWrite  = v.mem_write;
    bus.inMemRead   = v.mem_read;
    bus.inSize      = v.size;
    bus.inAluResult = v.addr;
    bus.inWriteData = v.wdata;
    bus.inWriteReg  = v.wreg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (fields mw,mr,rw,m2r,v,mis,be,addr,wd,wr,cnt)",
               name, act, exp);
    end
  endtask

  vec_t vecs[12];
  out_t zero_out;
  out_t a_out;
  in_t  a_in;
  in_t  bad_in;
  int   exp_cnt;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  initial begin
    zero_out = '0;

    // Table: expected counter values are cumulative from reset
    vecs[0]  = '{mk_in(1, 0, 0, 1, 0, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0),
                 mk_out(1, 0, 0, 0, 1, 0, 4'b1111, 32'h10, 32'hDEADBEEF, 5'd0, 8'd0)};
    vecs[1]  = '{mk_in(1, 1, 1, 0, 1, 2'b00, 32'h20, 32'h11111111, 5'd8),
                 mk_out(0, 1, 1, 1, 1, 0, 4'b0000, 32'h20, 32'h11111111, 5'd8, 8'd0)};
    vecs[2]  = '{mk_in(1, 1, 1, 0, 1, 2'b00, 32'h6, 32'h22222222, 5'd9),
                 mk_out(0, 0, 0, 1, 1, 1, 4'b0000, 32'h6, 32'h22222222, 5'd9, 8'd1)};
    vecs[3]  = '{mk_in(1, 1, 0, 0, 0, 2'b00, 32'h12345678, 32'hCAFEF00D, 5'd3),
                 mk_out(0, 0, 1, 0, 1, 0, 4'b0000, 32'h12345678, 32'hCAFEF00D, 5'd3, 8'd1)};
    vecs[4]  = '{mk_in(0, 1, 1, 1, 0, 2'b00, 32'h3, 32'h33333333, 5'd4),
                 mk_out(0, 0, 0, 0, 0, 0, 4'b0000, 32'h3, 32'h33333333, 5'd4, 8'd1)};
    vecs[5].stim = mk_in(1, 0, 0, 1, 0, 2'b10, 32'h103, 32'h000000AB, 5'd0);
    vecs[5].exp  = BL ? mk_out(1, 0, 0, 0, 1, 0, 4'b1000, 32'h103, 32'hABABABAB, 5'd0, 8'd1)
                      : mk_out(0, 0, 0, 0, 1, 1, 4'b0000, 32'h103, 32'h000000AB, 5'd0, 8'd2);
    vecs[6].stim = mk_in(1, 0, 0, 1, 0, 2'b01, 32'h202, 32'h00001234, 5'd0);
    vecs[6].exp  = BL ? mk_out(1, 0, 0, 0, 1, 0, 4'b1100, 32'h202, 32'h12341234, 5'd0, 8'd1)
                      : mk_out(0, 0, 0, 0, 1, 1, 4'b0000, 32'h202, 32'h00001234, 5'd0, 8'd3);
    vecs[7].stim = mk_in(1, 1, 1, 0, 1, 2'b01, 32'h201, 32'h0, 5'd7);
    vecs[7].exp  = mk_out(0, 0, 0, 1, 1, 1, 4'b0000, 32'h201, 32'h0, 5'd7, BL ? 8'd2 : 8'd4);
    vecs[8].stim = mk_in(1, 0, 0, 1, 0, 2'b11, 32'h40, 32'h00000055, 5'd0);
    vecs[8].exp  = mk_out(1, 0, 0, 0, 1, 0, 4'b1111, 32'h40, 32'h00000055, 5'd0,
                          BL ? 8'd2 : 8'd4);
    vecs[9].stim = mk_in(1, 1, 1, 0, 1, 2'b10, 32'h7, 32'h0, 5'd2);
    vecs[9].exp  = BL ? mk_out(0, 1, 1, 1, 1, 0, 4'b0000, 32'h7, 32'h0, 5'd2, 8'd2)
                      : mk_out(0, 0, 0, 1, 1, 1, 4'b0000, 32'h7, 32'h0, 5'd2, 8'd5);
    vecs[10].stim = mk_in(1, 0, 0, 1, 0, 2'b01, 32'h300, 32'hDEADBEEF, 5'd0);
    vecs[10].exp  = BL ? mk_out(1, 0, 0, 0, 1, 0, 4'b0011, 32'h300, 32'hBEEFBEEF, 5'd0, 8'd2)
                       : mk_out(1, 0, 0, 0, 1, 0, 4'b1111, 32'h300, 32'hDEADBEEF, 5'd0, 8'd5);
    vecs[11].stim = mk_in(1, 0, 0, 1, 0, 2'b10, 32'h301, 32'h0000005A, 5'd0);
    vecs[11].exp  = BL ? mk_out(1, 0, 0, 0, 1, 0, 4'b0010, 32'h301, 32'h5A5A5A5A, 5'd0, 8'd2)
                       : mk_out(0, 0, 0, 0, 1, 1, 4'b0000, 32'h301, 32'h0000005A, 5'd0, 8'd6);

    bus.inStall = 1'b0;
    bus.inFlush = 1'b0;
    apply('0);
    rst = 1'b1;
    #22;
    check("reset_state", zero_out);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].stim);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset mid-cycle with loaded state and nonzero counter
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", zero_out);
    #1;
    rst = 1'b0;
    apply(vecs[0].stim);
    #1;
    check("reset_release_no_capture_yet", zero_out);
    step();
    check("first_capture_after_reset", vecs[0].exp);

    // Stall: A must be held while conflicting (misaligned) inputs are present
    a_in   = mk_in(1, 1, 1, 0, 1, 2'b00, 32'h80, 32'h44444444, 5'd5);
    a_out  = mk_out(0, 1, 1, 1, 1, 0, 4'b0000, 32'h80, 32'h44444444, 5'd5, 8'd0);
    bad_in = mk_in(1, 0, 0, 1, 0, 2'b00, 32'h81, 32'h00000099, 5'd6);
    apply(a_in);
    step();
    check("load_a", a_out);
    apply(bad_in);
    bus.inStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), a_out);
    end

    // Stall and flush together: flush wins, counter untouched
    bus.inFlush = 1'b1;
    step();
    check("stall_flush_bubble", zero_out);

    // Misaligned store counts, then flush alone holds the counter
    bus.inStall = 1'b0;
    bus.inFlush = 1'b0;
    step();
    check("misaligned_store", mk_out(0, 0, 0, 0, 1, 1, 4'b0000, 32'h81, 32'h00000099,
                                     5'd6, 8'd1));
    bus.inFlush = 1'b1;
    step();
    check("flush_holds_cnt", mk_out(0, 0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 5'd0, 8'd1));
    bus.inFlush = 1'b0;

    // Saturation: 300 misaligned word loads after a fresh reset
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    apply(mk_in(1, 1, 1, 0, 1, 2'b00, 32'h6, 32'h0, 5'd1));
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (exp_cnt < 255) exp_cnt++;
      checks++;
      if ({bus.outMisalign, bus.MemRead, bus.outRegWrite, bus.outValid, bus.outMisalignCnt}
          !== {1'b1, 1'b0, 1'b0, 1'b1, 8'(exp_cnt)}) begin
        errors++;
        $display("FAIL sat%0d: got mis=%b rd=%b rw=%b v=%b cnt=%0d expected 1 0 0 1 cnt=%0d",
                 i, bus.outMisalign, bus.MemRead, bus.outRegWrite, bus.outValid,
                 bus.outMisalignCnt, exp_cnt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
